// File: rtl/execute_pkg.sv
// execute_pkg
// Shared definitions for the EX stage of the RV32IM pipeline.
//   - ALU operation encodings carried on opE (0..11)
//   - M-extension funct3 codes carried on funct3E
//   - Forward-select codes for ForwardAE/ForwardBE (11 behaves as 00)
//   - State encoding of the iterative divider
package execute_pkg;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;
  localparam logic [3:0] ALU_AUIPC = 4'd11;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } divState_t;

endpackage

// File: rtl/execute_div_iter.sv
// div_iter
// Iterative 32-step restoring divider used for DIV/DIVU/REM/REMU.
// Ports:
//   clk, rst       pipeline clock, synchronous active-high reset
//   i_flush        abandon the division in progress
//   i_start        a divide is sitting in EX and should begin
//   i_signed       treat operands as two's complement
//   i_dividend     dividend (A operand), latched at start
//   i_divisor      divisor (B operand), latched at start
//   o_busy         combinational: starting this cycle or iterating
//   o_done         the result below is final this cycle
//   o_quotient     sign-corrected quotient, special cases applied
//   o_remainder    sign-corrected remainder, special cases applied
module div_iter
  import execute_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_flush,
  input  logic        i_start,
  input  logic        i_signed,
  input  logic [31:0] i_dividend,
  input  logic [31:0] i_divisor,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_quotient,
  output logic [31:0] o_remainder
);

  divState_t   r_state;
  logic [4:0]  r_count;
  logic [31:0] r_quo;
  logic [31:0] r_rem;
  logic [31:0] r_divisor;
  logic [31:0] r_dividend;
  logic        r_negQ;
  logic        r_negR;
  logic        r_divZero;
  logic        r_overflow;
  logic [32:0] w_shifted;
  logic [32:0] w_trial;

  // r_quo starts out holding the dividend magnitude; its MSB is shifted into
  // the partial remainder each step while quotient bits fill in from the LSB.
  // A borrow out of the 33-bit trial subtraction means "does not fit".
  assign w_shifted = {r_rem, r_quo[31]};
  assign w_trial   = w_shifted - {1'b0, r_divisor};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= DIV_IDLE;
      r_count    <= '0;
      r_quo      <= '0;
      r_rem      <= '0;
      r_divisor  <= '0;
      r_dividend <= '0;
      r_negQ     <= 1'b0;
      r_negR     <= 1'b0;
      r_divZero  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        DIV_IDLE: begin
          if (i_start && !i_flush) begin
            r_state    <= DIV_RUN;
            r_count    <= 5'd31;
            r_quo      <= (i_signed && i_dividend[31]) ? -i_dividend : i_dividend;
            r_rem      <= '0;
            r_divisor  <= (i_signed && i_divisor[31]) ? -i_divisor : i_divisor;
            r_dividend <= i_dividend;
            r_negQ     <= i_signed & (i_dividend[31] ^ i_divisor[31]);
            r_negR     <= i_signed & i_dividend[31];
            r_divZero  <= (i_divisor == 32'd0);
            r_overflow <= i_signed && (i_dividend == 32'h8000_0000) &&
                          (i_divisor == 32'hFFFF_FFFF);
          end
        end
        DIV_RUN: begin
          if (i_flush) begin
            r_state <= DIV_IDLE;
          end else begin
            r_quo   <= {r_quo[30:0], ~w_trial[32]};
            r_rem   <= w_trial[32] ? w_shifted[31:0] : w_trial[31:0];
            r_count <= r_count - 5'd1;
            if (r_count == 5'd0) begin
              r_state <= DIV_DONE;
            end
          end
        end
        default: r_state <= DIV_IDLE;
      endcase
    end
  end

  assign o_busy = (r_state == DIV_RUN) ||
                  ((r_state == DIV_IDLE) && i_start && !i_flush);
  assign o_done = (r_state == DIV_DONE);

  // Divide-by-zero and signed overflow override the iterated result.
  always_comb begin
    o_quotient  = r_negQ ? -r_quo : r_quo;
    o_remainder = r_negR ? -r_rem : r_rem;
    if (r_divZero) begin
      o_quotient  = 32'hFFFF_FFFF;
      o_remainder = r_dividend;
    end else if (r_overflow) begin
      o_quotient  = 32'h8000_0000;
      o_remainder = 32'd0;
    end
  end

endmodule

// File: rtl/execute.sv
// execute
// EX stage of the five-stage RV32IM pipeline plus the EX/MEM register.
// Ports:
//   clk, rst                 pipeline clock, synchronous active-high reset
//   flush                    bubble EX/MEM and abort a running divide
//   validE                   ID/EX holds a real instruction
//   opE, mdE, funct3E        ALU op / M-extension select
//   r1E, r2E, immE, pcE      operands, immediate, instruction PC
//   ALUSrcE                  B operand is immE (1) or forwarded r2 (0)
//   ForwardAE, ForwardBE     forward selects; ResultW / ALUoutM sources
//   rdE, RegWriteE, MemtoRegE, MemWriteE, strCtrlE   control to pass on
//   busyE                    divider occupied, hazard unit stalls front end
//   ALUoutM, r2M, rdM, RegWriteM, MemtoRegM, MemWriteM, strCtrlM
//                            EX/MEM register outputs
module execute
  import execute_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        validE,
  input  logic [3:0]  opE,
  input  logic        mdE,
  input  logic [2:0]  funct3E,
  input  logic [31:0] r1E,
  input  logic [31:0] r2E,
  input  logic [31:0] immE,
  input  logic [31:0] pcE,
  input  logic        ALUSrcE,
  input  logic [1:0]  ForwardAE,
  input  logic [1:0]  ForwardBE,
  input  logic [31:0] ResultW,
  input  logic [4:0]  rdE,
  input  logic        RegWriteE,
  input  logic        MemtoRegE,
  input  logic        MemWriteE,
  input  logic [2:0]  strCtrlE,
  output logic        busyE,
  output logic [31:0] ALUoutM,
  output logic [31:0] r2M,
  output logic [4:0]  rdM,
  output logic        RegWriteM,
  output logic        MemtoRegM,
  output logic        MemWriteM,
  output logic [2:0]  strCtrlM
);

  logic [31:0]        w_srcA;
  logic [31:0]        w_storeData;
  logic [31:0]        w_srcB;
  logic [31:0]        w_aluResult;
  logic [31:0]        w_mulResult;
  logic [31:0]        w_divResult;
  logic [31:0]        w_result;
  logic [31:0]        w_quotient;
  logic [31:0]        w_remainder;
  logic signed [32:0] w_mulA;
  logic signed [32:0] w_mulB;
  logic signed [65:0] w_product;
  logic               w_isDiv;
  logic               w_divStart;
  logic               w_divBusy;
  logic               w_divDone;

  always_comb begin
    case (ForwardAE)
      FWD_WB:  w_srcA = ResultW;
      FWD_MEM: w_srcA = ALUoutM;
      default: w_srcA = r1E;
    endcase
    case (ForwardBE)
      FWD_WB:  w_storeData = ResultW;
      FWD_MEM: w_storeData = ALUoutM;
      default: w_storeData = r2E;
    endcase
  end

  assign w_srcB = ALUSrcE ? immE : w_storeData;

  always_comb begin
    case (opE)
      ALU_ADD:   w_aluResult = w_srcA + w_srcB;
      ALU_SUB:   w_aluResult = w_srcA - w_srcB;
      ALU_SLL:   w_aluResult = w_srcA << w_srcB[4:0];
      ALU_SLT:   w_aluResult = {31'd0, $signed(w_srcA) < $signed(w_srcB)};
      ALU_SLTU:  w_aluResult = {31'd0, w_srcA < w_srcB};
      ALU_XOR:   w_aluResult = w_srcA ^ w_srcB;
      ALU_SRL:   w_aluResult = w_srcA >> w_srcB[4:0];
      ALU_SRA:   w_aluResult = $signed(w_srcA) >>> w_srcB[4:0];
      ALU_OR:    w_aluResult = w_srcA | w_srcB;
      ALU_AND:   w_aluResult = w_srcA & w_srcB;
      ALU_PASSB: w_aluResult = w_srcB;
      ALU_AUIPC: w_aluResult = pcE + w_srcB;
      default:   w_aluResult = 32'd0;
    endcase
  end

  // One 33x33 signed multiplier covers all four variants: the extra top bit
  // is the sign for signed operands and zero for unsigned ones.
  always_comb begin
    w_mulA = {(funct3E != MD_MULHU) & w_srcA[31], w_srcA};
    w_mulB = {((funct3E == MD_MUL) || (funct3E == MD_MULH)) & w_srcB[31], w_srcB};
  end

  assign w_product   = 66'(w_mulA) * 66'(w_mulB);
  assign w_mulResult = (funct3E == MD_MUL) ? w_product[31:0] : w_product[63:32];

  assign w_isDiv    = mdE & funct3E[2];
  assign w_divStart = validE & w_isDiv & ~flush;

  div_iter u_divIter (
    .clk         (clk),
    .rst         (rst),
    .i_flush     (flush),
    .i_start     (w_divStart),
    .i_signed    (~funct3E[0]),
    .i_dividend  (w_srcA),
    .i_divisor   (w_srcB),
    .o_busy      (w_divBusy),
    .o_done      (w_divDone),
    .o_quotient  (w_quotient),
    .o_remainder (w_remainder)
  );

  assign busyE       = w_divBusy;
  assign w_divResult = w_divDone ? (funct3E[1] ? w_remainder : w_quotient) : 32'd0;
  assign w_result    = w_isDiv ? w_divResult : (mdE ? w_mulResult : w_aluResult);

  // EX/MEM register; a stalled or empty EX stage sends a zeroed bubble.
  always_ff @(posedge clk) begin
    if (rst || flush || w_divBusy || !validE) begin
      ALUoutM   <= '0;
      r2M       <= '0;
      rdM       <= '0;
      RegWriteM <= 1'b0;
      MemtoRegM <= 1'b0;
      MemWriteM <= 1'b0;
      strCtrlM  <= '0;
    end else begin
      ALUoutM   <= w_result;
      r2M       <= w_storeData;
      rdM       <= rdE;
      RegWriteM <= RegWriteE;
      MemtoRegM <= MemtoRegE;
      MemWriteM <= MemWriteE;
      strCtrlM  <= strCtrlE;
    end
  end

endmodule

// File: tb/tb_execute.sv
// tb_execute
// Self-checking bench for the EX stage: directed cases plus randomized
// operations compared against an arithmetic reference model.
module tb_execute;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        validE;
  logic [3:0]  opE;
  logic        mdE;
  logic [2:0]  funct3E;
  logic [31:0] r1E, r2E, immE, pcE;
  logic        ALUSrcE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] ResultW;
  logic [4:0]  rdE;
  logic        RegWriteE, MemtoRegE, MemWriteE;
  logic [2:0]  strCtrlE;
  logic        busyE;
  logic [31:0] ALUoutM, r2M;
  logic [4:0]  rdM;
  logic        RegWriteM, MemtoRegM, MemWriteM;
  logic [2:0]  strCtrlM;
  logic [74:0] obsVec;

  int checks = 0;
  int passed = 0;

  execute dut (
    .clk(clk), .rst(rst), .flush(flush), .validE(validE), .opE(opE), .mdE(mdE),
    .funct3E(funct3E), .r1E(r1E), .r2E(r2E), .immE(immE), .pcE(pcE),
    .ALUSrcE(ALUSrcE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ResultW(ResultW), .rdE(rdE), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE),
    .MemWriteE(MemWriteE), .strCtrlE(strCtrlE), .busyE(busyE), .ALUoutM(ALUoutM),
    .r2M(r2M), .rdM(rdM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
    .MemWriteM(MemWriteM), .strCtrlM(strCtrlM)
  );

  assign obsVec = {ALUoutM, r2M, rdM, RegWriteM, MemtoRegM, MemWriteM, strCtrlM};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference result from the RV32IM definitions using plain integer math.
  function automatic logic [31:0] refResult(input logic [3:0] op, input logic md,
                                            input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] pc);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    logic [31:0] r;
    int ia, ib;
    logic ovf;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    ia = a;
    ib = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    r = 32'd0;
    if (md) begin
      case (f3)
        3'd0: begin p = sa * sb; r = p[31:0]; end
        3'd1: begin p = sa * sb; r = p[63:32]; end
        3'd2: begin p = sa * ub; r = p[63:32]; end
        3'd3: begin p = ua * ub; r = p[63:32]; end
        3'd4: r = (b == 0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : ia / ib);
        3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
        3'd6: r = (b == 0) ? a : (ovf ? 32'd0 : ia % ib);
        default: r = (b == 0) ? a : a % b;
      endcase
    end else begin
      case (op)
        4'd0:  r = a + b;
        4'd1:  r = a - b;
        4'd2:  r = a << b[4:0];
        4'd3:  r = (ia < ib) ? 32'd1 : 32'd0;
        4'd4:  r = (ua < ub) ? 32'd1 : 32'd0;
        4'd5:  r = a ^ b;
        4'd6:  r = a >> b[4:0];
        4'd7:  begin p = sa >>> b[4:0]; r = p[31:0]; end
        4'd8:  r = a | b;
        4'd9:  r = a & b;
        4'd10: r = b;
        4'd11: r = pc + b;
        default: r = 32'd0;
      endcase
    end
    return r;
  endfunction

  // Presents one instruction in ID/EX.
  task automatic applyStimulus(input logic [3:0] op, input logic md, input logic [2:0] f3,
                               input logic [31:0] r1, input logic [31:0] r2,
                               input logic [31:0] imm, input logic [31:0] pc,
                               input logic alusrc, input logic [1:0] fa, input logic [1:0] fb,
                               input logic [31:0] resw, input logic [4:0] rd,
                               input logic rw, input logic m2r, input logic mw,
                               input logic [2:0] sc);
    validE = 1'b1; opE = op; mdE = md; funct3E = f3; r1E = r1; r2E = r2;
    immE = imm; pcE = pc; ALUSrcE = alusrc; ForwardAE = fa; ForwardBE = fb;
    ResultW = resw; rdE = rd; RegWriteE = rw; MemtoRegE = m2r; MemWriteE = mw;
    strCtrlE = sc;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    applyStimulus(4'd0, 1'b0, 3'd0, 32'd3, 32'd4, 32'd0, 32'd0, 1'b0, 2'd0, 2'd0,
                  32'd0, 5'd3, 1'b1, 1'b0, 1'b0, 3'd0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (obsVec !== 75'd0) $display("[TB] FAIL reset_outputs: got %h expected 0", obsVec);
    else passed++;
    validE = 1'b0;
    #1;
    checks++;
    if (busyE !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busyE);
    else passed++;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_alu_directed();
    applyStimulus(4'd10, 1'b0, 3'd0, 32'd0, 32'd0, 32'd5, 32'd0, 1'b1, 2'd0, 2'd0,
                  32'd0, 5'd1, 1'b1, 1'b0, 1'b0, 3'd0);
    @(posedge clk); #1;
    checks++;
    if (ALUoutM !== 32'd5) $display("[TB] FAIL lui5: got %h expected 5", ALUoutM);
    else passed++;
    applyStimulus(4'd0, 1'b0, 3'd0, 32'd99, 32'd7, 32'd0, 32'd0, 1'b0, 2'b10, 2'd0,
                  32'd0, 5'd2, 1'b1, 1'b0, 1'b0, 3'd0);
    @(posedge clk); #1;
    checks++;
    if ({ALUoutM, RegWriteM} !== {32'd12, 1'b1})
      $display("[TB] FAIL add_fwd_mem: got %h/%b expected 0000000c/1", ALUoutM, RegWriteM);
    else passed++;
    applyStimulus(4'd7, 1'b0, 3'd0, 32'h8000_0000, 32'd0, 32'd4, 32'd0, 1'b1, 2'd0, 2'd0,
                  32'd0, 5'd3, 1'b1, 1'b0, 1'b0, 3'd0);
    @(posedge clk); #1;
    checks++;
    if (ALUoutM !== 32'hF800_0000) $display("[TB] FAIL sra: got %h expected f8000000", ALUoutM);
    else passed++;
    applyStimulus(4'd4, 1'b0, 3'd0, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0, 2'd0, 2'd0,
                  32'd0, 5'd4, 1'b1, 1'b0, 1'b0, 3'd0);
    @(posedge clk); #1;
    checks++;
    if (ALUoutM !== 32'd1) $display("[TB] FAIL sltu: got %h expected 1", ALUoutM);
    else passed++;
  endtask

  task automatic test_mul_directed();
    applyStimulus(4'd0, 1'b1, 3'd1, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'd0, 1'b0,
                  2'd0, 2'd0, 32'd0, 5'd5, 1'b1, 1'b0, 1'b0, 3'd0);
    @(posedge clk); #1;
    checks++;
    if (ALUoutM !== 32'h4000_0000) $display("[TB] FAIL mulh: got %h expected 40000000", ALUoutM);
    else passed++;
    applyStimulus(4'd0, 1'b1, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0,
                  2'd0, 2'd0, 32'd0, 5'd6, 1'b1, 1'b0, 1'b0, 3'd0);
    @(posedge clk); #1;
    checks++;
    if (ALUoutM !== 32'hFFFF_FFFE) $display("[TB] FAIL mulhu: got %h expected fffffffe", ALUoutM);
    else passed++;
  endtask

  task automatic test_store();
    applyStimulus(4'd0, 1'b0, 3'd0, 32'h0000_1000, 32'h1111_1111, 32'h24, 32'd0, 1'b1,
                  2'd0, 2'b01, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b0, 1'b1, 3'b010);
    @(posedge clk); #1;
    checks++;
    if (obsVec !== {32'h0000_1024, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b0, 1'b1, 3'b010})
      $display("[TB] FAIL store: got %h expected %h", obsVec,
               {32'h0000_1024, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b0, 1'b1, 3'b010});
    else passed++;
    validE = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_random_ops();
    logic [31:0] prevAlu, r1, r2, imm, pc, resw, a, sd, bop;
    logic [3:0]  op;
    logic        md, alusrc, v, rw, m2r, mw;
    logic [2:0]  f3, sc;
    logic [1:0]  fa, fb;
    logic [4:0]  rd;
    logic [74:0] exp;
    prevAlu = 32'd0;
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 11));
      md = ($urandom_range(0, 3) == 0);
      f3 = 3'($urandom_range(0, 3));
      r1 = $urandom; r2 = $urandom; imm = $urandom; pc = $urandom; resw = $urandom;
      if ($urandom_range(0, 3) == 0) r2 = 32'hFFFF_FFFF;
      if ($urandom_range(0, 3) == 0) r1 = 32'h8000_0000;
      alusrc = 1'($urandom_range(0, 1));
      fa = 2'($urandom_range(0, 3));
      fb = 2'($urandom_range(0, 3));
      rd = 5'($urandom); rw = 1'($urandom); m2r = 1'($urandom); mw = 1'($urandom);
      sc = 3'($urandom);
      v = ($urandom_range(0, 7) != 0);
      applyStimulus(op, md, f3, r1, r2, imm, pc, alusrc, fa, fb, resw, rd, rw, m2r, mw, sc);
      validE = v;
      a   = (fa == 2'b01) ? resw : ((fa == 2'b10) ? prevAlu : r1);
      sd  = (fb == 2'b01) ? resw : ((fb == 2'b10) ? prevAlu : r2);
      bop = alusrc ? imm : sd;
      exp = v ? {refResult(op, md, f3, a, bop, pc), sd, rd, rw, m2r, mw, sc} : 75'd0;
      @(posedge clk); #1;
      checks++;
      if (obsVec !== exp)
        $display("[TB] FAIL random_op%0d (op=%0d md=%b f3=%0d): got %h expected %h",
                 i, op, md, f3, obsVec, exp);
      else passed++;
      prevAlu = exp[74:43];
    end
    validE = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_divide();
    logic [2:0]  f3s  [9];
    logic [31:0] as   [9];
    logic [31:0] bs   [9];
    logic [31:0] exps [9];
    int          busyCount, bubbleBad;
    f3s[0] = 3'd4; as[0] = 32'hFFFF_FFF9; bs[0] = 32'd2;          exps[0] = 32'hFFFF_FFFD;
    f3s[1] = 3'd6; as[1] = 32'hFFFF_FFF9; bs[1] = 32'd2;          exps[1] = 32'hFFFF_FFFF;
    f3s[2] = 3'd5; as[2] = 32'h1234_5678; bs[2] = 32'd0;          exps[2] = 32'hFFFF_FFFF;
    f3s[3] = 3'd6; as[3] = 32'h8000_0000; bs[3] = 32'hFFFF_FFFF;  exps[3] = 32'd0;
    f3s[4] = 3'd4; as[4] = 32'h8000_0000; bs[4] = 32'hFFFF_FFFF;  exps[4] = 32'h8000_0000;
    for (int k = 5; k < 9; k++) begin
      f3s[k] = 3'($urandom_range(4, 7));
      as[k]  = $urandom;
      bs[k]  = (k == 8) ? 32'd0 : ($urandom >> $urandom_range(0, 28));
      exps[k] = refResult(4'd0, 1'b1, f3s[k], as[k], bs[k], 32'd0);
    end
    for (int k = 0; k < 9; k++) begin
      applyStimulus(4'd0, 1'b1, f3s[k], as[k], bs[k], 32'd0, 32'd0, 1'b0, 2'd0, 2'd0,
                    32'd0, 5'(k + 10), 1'b1, 1'b0, 1'b0, 3'd0);
      #1;
      busyCount = busyE ? 1 : 0;
      bubbleBad = 0;
      for (int e = 1; e <= 33; e++) begin
        @(posedge clk); #1;
        if (busyE === 1'b1) busyCount++;
        if (obsVec !== 75'd0) bubbleBad++;
      end
      checks++;
      if (busyCount != 33) $display("[TB] FAIL div%0d_busy_cycles: got %0d expected 33", k, busyCount);
      else passed++;
      checks++;
      if (bubbleBad != 0) $display("[TB] FAIL div%0d_bubbles: got %0d non-bubble cycles expected 0", k, bubbleBad);
      else passed++;
      @(posedge clk); #1;
      checks++;
      if (obsVec !== {exps[k], bs[k], 5'(k + 10), 1'b1, 1'b0, 1'b0, 3'd0})
        $display("[TB] FAIL div%0d_result (f3=%0d a=%h b=%h): got %h expected %h", k, f3s[k],
                 as[k], bs[k], ALUoutM, exps[k]);
      else passed++;
      validE = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_flush();
    applyStimulus(4'd0, 1'b1, 3'd4, 32'd100, 32'd3, 32'd0, 32'd0, 1'b0, 2'd0, 2'd0,
                  32'd0, 5'd7, 1'b1, 1'b0, 1'b0, 3'd0);
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    validE = 1'b0;
    #1;
    checks++;
    if ({busyE, obsVec} !== 76'd0) $display("[TB] FAIL flush_mid_div: busy=%b out=%h expected all 0", busyE, obsVec);
    else passed++;
    applyStimulus(4'd0, 1'b0, 3'd0, 32'd20, 32'd22, 32'd0, 32'd0, 1'b0, 2'd0, 2'd0,
                  32'd0, 5'd8, 1'b1, 1'b0, 1'b0, 3'd0);
    @(posedge clk); #1;
    checks++;
    if (obsVec !== {32'd42, 32'd22, 5'd8, 1'b1, 1'b0, 1'b0, 3'd0})
      $display("[TB] FAIL add_after_flush: got %h expected 42", ALUoutM);
    else passed++;
    applyStimulus(4'd0, 1'b1, 3'd5, 32'd50, 32'd5, 32'd0, 32'd0, 1'b0, 2'd0, 2'd0,
                  32'd0, 5'd9, 1'b1, 1'b0, 1'b0, 3'd0);
    flush = 1'b1;
    #1;
    checks++;
    if (busyE !== 1'b0) $display("[TB] FAIL flush_beats_div_busy: got %b expected 0", busyE);
    else passed++;
    @(posedge clk); #1;
    flush = 1'b0;
    applyStimulus(4'd1, 1'b0, 3'd0, 32'd9, 32'd4, 32'd0, 32'd0, 1'b0, 2'd0, 2'd0,
                  32'd0, 5'd11, 1'b1, 1'b0, 1'b0, 3'd0);
    #1;
    checks++;
    if ({busyE, obsVec} !== 76'd0) $display("[TB] FAIL flush_beats_div_out: busy=%b out=%h expected all 0", busyE, obsVec);
    else passed++;
    @(posedge clk); #1;
    checks++;
    if (obsVec !== {32'd5, 32'd4, 5'd11, 1'b1, 1'b0, 1'b0, 3'd0})
      $display("[TB] FAIL sub_after_flush: got %h expected 5", ALUoutM);
    else passed++;
    validE = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; validE = 1'b0; opE = '0; mdE = 1'b0; funct3E = '0;
    r1E = '0; r2E = '0; immE = '0; pcE = '0; ALUSrcE = 1'b0; ForwardAE = '0;
    ForwardBE = '0; ResultW = '0; rdE = '0; RegWriteE = 1'b0; MemtoRegE = 1'b0;
    MemWriteE = 1'b0; strCtrlE = '0;
    test_reset();
    test_alu_directed();
    test_mul_directed();
    test_store();
    test_random_ops();
    test_divide();
    test_flush();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/execute.md
# execute

Execute stage (EX) of the five-stage RV32IM pipeline, together with the EX/MEM pipeline register. It forwards operands and evaluates RV32I ALU operations and single-cycle multiplies. Divides and remainders run on an iterative 32-step divider that stalls the front of the pipeline. Its registered outputs drive the memory stage directly: store strobe, ALU result/address, rd, store data, control.

## Interface
Parameters:
- None. Datapath fixed at 32 bits.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  insert bubble into EX/MEM; abort any division in progress
- validE  in  1  ID/EX holds a real instruction
- opE  in  4  ALU op: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB (LUI), 11 AUIPC (pcE+B)
- mdE  in  1  M-extension op; funct3E selects it and opE is ignored
- funct3E  in  3  M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- r1E, r2E  in  32  register-file operands
- immE, pcE  in  32  immediate, instruction PC
- ALUSrcE  in  1  B operand: 1 = immE, 0 = forwarded r2
- ForwardAE, ForwardBE  in  2  00 register, 01 ResultW, 10 ALUoutM; 11 behaves as 00
- ResultW  in  32  writeback result
- rdE  in  5; RegWriteE, MemtoRegE, MemWriteE  in  1; strCtrlE  in  3  (funct3 of load/store)
- busyE  out  1  divider occupied; hazard unit holds PC, IF/ID and ID/EX
- ALUoutM, r2M  out  32  result/address, forwarded store data
- rdM  out  5; RegWriteM, MemtoRegM, MemWriteM  out  1; strCtrlM  out  3

## Operation
- A operand = forward mux over r1E. Store data is the forward mux over r2E and goes to r2M. B operand = ALUSrcE ? immE : store data.
- Shift amount = B[4:0]. SLT/SLTU write 0 or 1.
- MUL* results come from a combinational 33x33 signed product and complete in one cycle.
  - MUL takes the low 32 bits; the other three take the high 32.
- Divider FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN: when validE & mdE & funct3E[2] & !flush. Operands are latched sign-corrected and the 5-bit counter is set to 31.
  - RUN: one restoring-division step per cycle. Counter decrements; at 0, go to DONE.
  - DONE: result is presented to EX/MEM and the FSM returns to IDLE.
  - Operands are latched once, so later forwarding changes are ignored.
- Special results, applied in DONE with unchanged latency:
  - Divisor 0: quotient 0xFFFFFFFF, remainder = dividend.
  - Signed 0x80000000 / -1: quotient 0x80000000, remainder 0.
- EX/MEM register, updated every cycle:
  - rst | flush: all outputs 0.
  - Else if busyE, or validE = 0: bubble. RegWriteM, MemtoRegM and MemWriteM are 0; data fields are don't-care but driven 0.
  - Else capture the result and control.
- flush during RUN/DONE returns the FSM to IDLE next cycle. flush wins over a divide arriving in the same cycle.

## Timing
- Reset values: every output 0, FSM in IDLE, busyE 0.
- Non-divide ops: registered one cycle after entering EX.
- busyE is combinational. It is high from the cycle a divide enters EX (IDLE) through all 32 RUN cycles, i.e. 33 cycles, and low in DONE.
- A divide's result is on ALUoutM after the 34th edge counted from its arrival in EX.
- While busyE is high the instruction stays in ID/EX with inputs stable. The bench must hold inputs stable.
- No combinational path from busyE to any EX/MEM input other than the bubble select.

## Structure
- Shared package holds:
  - ALU op encodings 0-11
  - M funct3 codes
  - Forward-select constants 00/01/10
  - Divider state enum
- One sub-module, div_iter: start, signed, operands in; busy, done, quotient, remainder out. It contains the FSM and counter.
- ALU, multiplier, forward muxes and EX/MEM register stay in execute.

## Test plan
- ADD with ForwardAE=10, ALUoutM=5, r2E=7 -> ALUoutM=12 next cycle, RegWriteM=1.
- SRA with A=0x80000000, immE=4 -> 0xF8000000. SLTU 1 vs 0xFFFFFFFF -> 1.
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
- DIV -7/2 -> busyE high 33 cycles with bubbles in EX/MEM, then ALUoutM=0xFFFFFFFD. REM -7/2 -> 0xFFFFFFFF.
- DIVU x/0 -> 0xFFFFFFFF. REM 0x80000000/-1 -> 0. Both with the full 34-cycle latency.
- flush at cycle 10 of a divide -> busyE low the next cycle, EX/MEM all 0. A following ADD completes normally.
- Store with ForwardBE=01, ResultW=0xDEADBEEF, ALUSrcE=1 -> r2M=0xDEADBEEF, ALUoutM=A+imm, MemWriteM=1.
